// File: rtl/serial_demux_controller.sv
// Step-driven controller for a serial demultiplexer: start bit, 2 port bits,
// 4 length bits, counter load, payload transfer, done; counts completed frames.
module serial_demux_controller #(
  parameter logic START_LEVEL = 1'b0,
  parameter int   FRAME_W     = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clkEN,
  input  logic               SerIn,
  input  logic               abort,
  input  logic               co1,
  input  logic               co2,
  input  logic               coD,
  output logic               sh_en,
  output logic               cnt1,
  output logic               sh_enD,
  output logic               cnt2,
  output logic               ldcntD,
  output logic               cntD,
  output logic               valid,
  output logic               done,
  output logic               busy,
  output logic [2:0]         state,
  output logic [FRAME_W-1:0] frame_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PORT  = 3'd1,
    DNUM  = 3'd2,
    LOAD  = 3'd3,
    TRANS = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [FRAME_W-1:0] FRAME_ONE = {{(FRAME_W-1){1'b0}}, 1'b1};

  // Kept as a plain vector so unused codes 6-7 are representable and recoverable.
  logic [2:0]         state_reg;
  state_t             state_next;
  logic [FRAME_W-1:0] frame_cnt_reg;
  logic               frame_inc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      frame_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (frame_inc)
        frame_cnt_reg <= frame_cnt_reg + FRAME_ONE;
    end
  end

  always_comb begin
    state_next = IDLE;
    frame_inc  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clkEN && !abort && (SerIn == START_LEVEL))
          state_next = PORT;
        else
          state_next = IDLE;
      end
      PORT: begin
        if (clkEN && abort)
          state_next = IDLE;
        else if (clkEN && co1)
          state_next = DNUM;
        else
          state_next = PORT;
      end
      DNUM: begin
        if (clkEN && abort)
          state_next = IDLE;
        else if (clkEN && co2)
          state_next = LOAD;
        else
          state_next = DNUM;
      end
      LOAD: begin
        if (clkEN)
          state_next = abort ? IDLE : TRANS;
        else
          state_next = LOAD;
      end
      TRANS: begin
        if (clkEN && abort)
          state_next = IDLE;
        else if (clkEN && coD)
          state_next = DONE;
        else
          state_next = TRANS;
      end
      DONE: begin
        // An abort on the closing step discards the frame instead of counting it.
        if (clkEN) begin
          state_next = IDLE;
          frame_inc  = !abort;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sh_en  = 1'b0;
    cnt1   = 1'b0;
    sh_enD = 1'b0;
    cnt2   = 1'b0;
    ldcntD = 1'b0;
    cntD   = 1'b0;
    valid  = 1'b0;
    done   = 1'b0;
    busy   = (state_reg != IDLE);
    case (state_reg)
      PORT: begin
        sh_en = 1'b1;
        cnt1  = 1'b1;
      end
      DNUM: begin
        sh_enD = 1'b1;
        cnt2   = 1'b1;
      end
      LOAD:  ldcntD = 1'b1;
      TRANS: begin
        cntD  = 1'b1;
        valid = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign state     = state_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_serial_demux_controller.sv
// Directed bench for serial_demux_controller: vector table for two full frames,
// then hand sequences for hold, abort, async reset, illegal code and counter wrap.
module tb_serial_demux_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clkEN = 1'b0;
  logic       SerIn = 1'b1;
  logic       abort = 1'b0;
  logic       co1 = 1'b0;
  logic       co2 = 1'b0;
  logic       coD = 1'b0;
  logic       sh_en, cnt1, sh_enD, cnt2, ldcntD, cntD, valid, done, busy;
  logic [2:0] state;
  logic [7:0] frame_cnt;

  serial_demux_controller #(.START_LEVEL(1'b0), .FRAME_W(8)) dut (
    .clock(clock), .reset(reset), .clkEN(clkEN), .SerIn(SerIn), .abort(abort),
    .co1(co1), .co2(co2), .coD(coD),
    .sh_en(sh_en), .cnt1(cnt1), .sh_enD(sh_enD), .cnt2(cnt2), .ldcntD(ldcntD),
    .cntD(cntD), .valid(valid), .done(done), .busy(busy),
    .state(state), .frame_cnt(frame_cnt)
  );

  always #5 clock = ~clock;

  // {state, sh_en,cnt1,sh_enD,cnt2,ldcntD,cntD,valid,done,busy, frame_cnt}
  logic [19:0] snap;
  assign snap = {state, sh_en, cnt1, sh_enD, cnt2, ldcntD, cntD, valid, done, busy, frame_cnt};

  int          vectors = 0;
  int          miscompares = 0;
  logic [19:0] excl_errs = '0;

  always @(negedge clock)
    if (!reset && ($countones({sh_en, sh_enD, ldcntD, cntD}) > 1))
      excl_errs <= excl_errs + 20'd1;

  // Hand-written strobe pattern for each state code.
  function automatic logic [8:0] outs_of(input logic [2:0] st);
    case (st)
      3'd0:    return 9'b000000000;
      3'd1:    return 9'b110000001;
      3'd2:    return 9'b001100001;
      3'd3:    return 9'b000010001;
      3'd4:    return 9'b000001101;
      3'd5:    return 9'b000000011;
      default: return 9'b000000001;
    endcase
  endfunction

  function automatic logic [19:0] exp_snap(input logic [2:0] st, input logic [7:0] fc);
    return {st, outs_of(st), fc};
  endfunction

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got state=%0d strobes=%b fc=%0d, want state=%0d strobes=%b fc=%0d",
               name, act[19:17], act[16:8], act[7:0], exp[19:17], exp[16:8], exp[7:0]);
    end else begin
      $display("ok   %s: state=%0d strobes=%b fc=%0d", name, act[19:17], act[16:8], act[7:0]);
    end
  endtask

  // One clock with inputs {clkEN, SerIn, abort, co1, co2, coD}; sampled 1 time unit after the edge.
  task automatic pulse(input logic [5:0] in);
    @(negedge clock);
    {clkEN, SerIn, abort, co1, co2, coD} = in;
    @(posedge clock);
    #1;
    clkEN = 1'b0; abort = 1'b0; co1 = 1'b0; co2 = 1'b0; coD = 1'b0;
  endtask

  task automatic to_trans();
    pulse(6'b100000);
    pulse(6'b110000);
    pulse(6'b100100);
    pulse(6'b100000);
    pulse(6'b100000);
    pulse(6'b110000);
    pulse(6'b110010);
    pulse(6'b100000);
  endtask

  task automatic one_frame();
    to_trans();
    pulse(6'b100001);
    pulse(6'b110000);
  endtask

  typedef struct {
    logic [5:0] in;
    logic [2:0] st;
    logic [7:0] fc;
  } vec_t;

  vec_t tbl [24];

  initial begin
    tbl[0]  = '{6'b100000, 3'd1, 8'd0};
    tbl[1]  = '{6'b110000, 3'd1, 8'd0};
    tbl[2]  = '{6'b100100, 3'd2, 8'd0};
    tbl[3]  = '{6'b100000, 3'd2, 8'd0};
    tbl[4]  = '{6'b100000, 3'd2, 8'd0};
    tbl[5]  = '{6'b110000, 3'd2, 8'd0};
    tbl[6]  = '{6'b110010, 3'd3, 8'd0};
    tbl[7]  = '{6'b110000, 3'd4, 8'd0};
    tbl[8]  = '{6'b100000, 3'd4, 8'd0};
    tbl[9]  = '{6'b110000, 3'd4, 8'd0};
    tbl[10] = '{6'b100001, 3'd5, 8'd0};
    tbl[11] = '{6'b100000, 3'd0, 8'd1};
    tbl[12] = '{6'b000000, 3'd0, 8'd1};
    tbl[13] = '{6'b110000, 3'd0, 8'd1};
    tbl[14] = '{6'b100100, 3'd1, 8'd1};
    tbl[15] = '{6'b100011, 3'd1, 8'd1};
    tbl[16] = '{6'b100100, 3'd2, 8'd1};
    tbl[17] = '{6'b100101, 3'd2, 8'd1};
    tbl[18] = '{6'b000010, 3'd2, 8'd1};
    tbl[19] = '{6'b100010, 3'd3, 8'd1};
    tbl[20] = '{6'b100111, 3'd4, 8'd1};
    tbl[21] = '{6'b100001, 3'd5, 8'd1};
    tbl[22] = '{6'b000000, 3'd5, 8'd1};
    tbl[23] = '{6'b100000, 3'd0, 8'd2};

    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset", snap, exp_snap(3'd0, 8'd0));
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      pulse(tbl[i].in);
      chk($sformatf("vec%0d", i), snap, exp_snap(tbl[i].st, tbl[i].fc));
    end

    // Hold in TRANS with clkEN low while other inputs toggle.
    to_trans();
    chk("hold_entry", snap, exp_snap(3'd4, 8'd2));
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      SerIn = ~SerIn;
      coD   = ~coD;
      #1;
      chk($sformatf("hold%0d", i), snap, exp_snap(3'd4, 8'd2));
    end
    coD = 1'b0;
    pulse(6'b100001);
    pulse(6'b100000);
    chk("hold_exit", snap, exp_snap(3'd0, 8'd3));

    // Abort in DNUM after two length bits, then a clean frame.
    pulse(6'b100000);
    pulse(6'b110000);
    pulse(6'b100100);
    pulse(6'b100000);
    pulse(6'b100000);
    chk("pre_abort", snap, exp_snap(3'd2, 8'd3));
    pulse(6'b101010);
    chk("abort_dnum", snap, exp_snap(3'd0, 8'd3));
    one_frame();
    chk("after_abort", snap, exp_snap(3'd0, 8'd4));

    // Abort on the DONE step must not count the frame.
    to_trans();
    pulse(6'b100001);
    chk("at_done", snap, exp_snap(3'd5, 8'd4));
    pulse(6'b101000);
    chk("abort_done", snap, exp_snap(3'd0, 8'd4));

    // Abort beats a start bit in IDLE.
    pulse(6'b101000);
    chk("abort_idle", snap, exp_snap(3'd0, 8'd4));

    // Asynchronous reset between edges while in TRANS.
    to_trans();
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", snap, exp_snap(3'd0, 8'd0));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    SerIn = 1'b0;
    @(posedge clock);
    #1;
    chk("no_step_no_start", snap, exp_snap(3'd0, 8'd0));
    pulse(6'b110000);
    chk("idle_level", snap, exp_snap(3'd0, 8'd0));
    pulse(6'b100000);
    chk("fresh_start", snap, exp_snap(3'd1, 8'd0));

    // Illegal code recovery.
    @(negedge clock);
    force dut.state_reg = 3'd6;
    #1;
    chk("illegal_forced", snap, exp_snap(3'd6, 8'd0));
    release dut.state_reg;
    pulse(6'b110000);
    chk("illegal_recover", snap, exp_snap(3'd0, 8'd0));

    // Counter wrap over 256 frames.
    for (int i = 0; i < 255; i++)
      one_frame();
    chk("wrap_255", snap, exp_snap(3'd0, 8'd255));
    one_frame();
    chk("wrap_256", snap, exp_snap(3'd0, 8'd0));

    vectors++;
    if (excl_errs !== 20'd0) begin
      miscompares++;
      $display("FAIL exclusivity: got %0d overlapping cycles, want 0", excl_errs);
    end else begin
      $display("ok   exclusivity: 0 overlapping cycles");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
